// File: rtl/ifetch_mem_responder_if.sv
// Fetch-request / response / IMEM-port bundle for ifetch_mem_responder.
// slave = the responder itself, master = fetcher plus instruction memory.
interface ifetch_mem_responder_if #(
  parameter int PC_W = 25
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [PC_W-1:0] req_pc_i;
  logic            flush_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [63:0]     resp_data_o;
  logic [PC_W-1:0] resp_pc_o;
  logic            mem_req_o;
  logic [PC_W-2:0] mem_addr_o;
  logic            mem_rvalid_i;
  logic [31:0]     mem_rdata_i;

  modport slave (
    input  req_valid_i, req_pc_i, flush_i, resp_ready_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_pc_o, mem_req_o, mem_addr_o
  );

  modport master (
    output req_valid_i, req_pc_i, flush_i, resp_ready_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_pc_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/ifetch_mem_responder.sv
// Builds a 64-bit halfword-aligned fetch window from 2 or 3 sequential 32-bit IMEM reads.
// Optional IFETCH_WORD_REUSE_EN: reuse the last received word when it is the first word of the next window.
module ifetch_mem_responder #(
  parameter int PC_W    = 25,
  parameter int MEM_LAT = 1
) (
  input logic                  clk,
  input logic                  reset,
  ifetch_mem_responder_if.slave bus
);
  if (MEM_LAT < 1) begin : g_lat_chk
    $error("MEM_LAT must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [1:0]      k_q;
  logic [31:0]     w0_q, w1_q;
  logic [63:0]     data_q;
  logic [63:0]     window;
  logic [PC_W-2:0] word_addr;
  logic            accept, rd_done, last_word;

`ifdef IFETCH_WORD_REUSE_EN
  logic [31:0]     buf_q;
  logic [PC_W-2:0] tag_q;
  logic            tag_valid_q;
  logic            reuse_hit;
  assign reuse_hit = tag_valid_q && (tag_q == bus.req_pc_i[PC_W-1:1]);
`endif

  assign word_addr = pc_q[PC_W-1:1] + (PC_W-1)'(k_q);
  assign last_word = (k_q == (pc_q[0] ? 2'd2 : 2'd1));
  // Misaligned window drops the low half of w0 and keeps only the low half of w2.
  assign window    = pc_q[0] ? {bus.mem_rdata_i[15:0], w1_q, w0_q[31:16]}
                             : {bus.mem_rdata_i, w0_q};

  assign bus.resp_data_o = data_q;
  assign bus.resp_pc_o   = pc_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    rd_done          = 1'b0;
    bus.req_ready_o  = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.mem_req_o    = 1'b0;
    bus.mem_addr_o   = '0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (!bus.flush_i && bus.req_valid_i) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = word_addr;
        state_d        = bus.flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        // A flush coinciding with the returning word leaves nothing outstanding.
        if (bus.flush_i) begin
          state_d = bus.mem_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (bus.mem_rvalid_i) begin
          rd_done = 1'b1;
          state_d = last_word ? S_RESP : S_ISSUE;
        end
      end
      S_RESP: begin
        bus.resp_valid_o = 1'b1;
        if (bus.flush_i || bus.resp_ready_i) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.mem_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      k_q    <= '0;
      w0_q   <= '0;
      w1_q   <= '0;
      data_q <= '0;
`ifdef IFETCH_WORD_REUSE_EN
      buf_q       <= '0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        pc_q <= bus.req_pc_i;
        k_q  <= '0;
`ifdef IFETCH_WORD_REUSE_EN
        if (reuse_hit) begin
          w0_q <= buf_q;
          k_q  <= 2'd1;
        end
`endif
      end
      if (rd_done) begin
        if (k_q == 2'd0)      w0_q <= bus.mem_rdata_i;
        else if (k_q == 2'd1) w1_q <= bus.mem_rdata_i;
        k_q <= k_q + 2'd1;
        if (last_word) data_q <= window;
`ifdef IFETCH_WORD_REUSE_EN
        buf_q       <= bus.mem_rdata_i;
        tag_q       <= word_addr;
        tag_valid_q <= 1'b1;
`endif
      end
`ifdef IFETCH_WORD_REUSE_EN
      if (bus.flush_i) tag_valid_q <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Randomized self-checking bench for ifetch_mem_responder against a halfword-level window model.
// Honours IFETCH_WORD_REUSE_EN in the expected read sequence.
module tb_ifetch_mem_responder;
    localparam int PC_W = 25;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifetch_mem_responder_if #(.PC_W(PC_W)) bus ();

    ifetch_mem_responder #(.PC_W(PC_W), .MEM_LAT(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0]     mem [int unsigned];
    logic [PC_W-2:0] issued_q[$];
    int unsigned     mem_lat = 1;
    int unsigned     mem_cnt = 0;
    logic [PC_W-2:0] mem_pend;

    logic            tag_valid = 1'b0;
    logic [PC_W-2:0] tag;

    task automatic check(input string tag_s, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag_s, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [PC_W-2:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {a[15:0] ^ 16'h5a5a, ~a[23:8]};
    endfunction

    // Window = four consecutive halfwords starting at pc, each fetched from its own word.
    function automatic logic [63:0] model_window(input logic [PC_W-1:0] pc);
        logic [63:0] win;
        for (int i = 0; i < 4; i++) begin
            logic [PC_W-1:0] p;
            logic [31:0]     w;
            p = pc + PC_W'(i);
            w = mem_read(p[PC_W-1:1]);
            win[16*i +: 16] = p[0] ? w[31:16] : w[15:0];
        end
        return win;
    endfunction

    // Memory: one response per strobe, mem_lat cycles after it.
    initial begin
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            bus.mem_rvalid_i = 1'b0;
            if (mem_cnt != 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = mem_read(mem_pend);
                end
            end
            if (!reset && bus.mem_req_o) begin
                check("mem_single_outstanding", 64'(mem_cnt != 0), 64'd0);
                issued_q.push_back(bus.mem_addr_o);
                mem_pend = bus.mem_addr_o;
                mem_cnt  = mem_lat;
            end
        end
    end

    task automatic start_req(input logic [PC_W-1:0] pc);
        int unsigned n = 0;
        while (!bus.req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 64'(bus.req_ready_o), 64'd1);
        issued_q.delete();
        bus.req_valid_i = 1'b1;
        bus.req_pc_i    = pc;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_pc_i    = $urandom();
    endtask

    task automatic do_req(input logic [PC_W-1:0] pc, input int unsigned lat, input int unsigned stall);
        logic [PC_W-2:0] exp_q[$];
        logic [63:0]     exp_data;
        int unsigned     n, k0, cyc;
        mem_lat  = lat;
        exp_data = model_window(pc);
        n  = pc[0] ? 3 : 2;
        k0 = 0;
`ifdef IFETCH_WORD_REUSE_EN
        if (tag_valid && tag == pc[PC_W-1:1]) k0 = 1;
`endif
        for (int unsigned k = k0; k < n; k++) exp_q.push_back(pc[PC_W-1:1] + (PC_W-1)'(k));

        start_req(pc);
        cyc = 1;
        while (!bus.resp_valid_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.resp_valid_o) begin
            check("resp_timeout", 64'd0, 64'd1);
            return;
        end
        check("resp_latency", 64'(cyc), 64'(exp_q.size() * (lat + 1) + 1));
        for (int unsigned s = 0; s < stall; s++) begin
            check("bp_valid", 64'(bus.resp_valid_o), 64'd1);
            check("bp_data", bus.resp_data_o, exp_data);
            check("bp_ready_low", 64'(bus.req_ready_o), 64'd0);
            check("bp_no_mem_req", 64'(bus.mem_req_o), 64'd0);
            @(negedge clk);
        end
        check("resp_data", bus.resp_data_o, exp_data);
        check("resp_pc", 64'(bus.resp_pc_o), 64'(pc));
        check("read_count", 64'(issued_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < issued_q.size(); i++)
            check("read_addr", 64'(issued_q[i]), 64'(exp_q[i]));
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
        check("post_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check("post_resp_ready", 64'(bus.req_ready_o), 64'd1);
        tag_valid = 1'b1;
        tag       = exp_q[exp_q.size()-1];
    endtask

    logic [PC_W-1:0] pc_r;

    initial begin
        reset            = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.req_pc_i     = '0;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        check("rst_resp_data", bus.resp_data_o, 64'd0);
        check("rst_resp_pc", 64'(bus.resp_pc_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Aligned window.
        mem[8] = 32'h11110000;
        mem[9] = 32'h33332222;
        do_req(25'h10, 1, 0);
        check("aligned_const", model_window(25'h10), 64'h3333222211110000);

        // Misaligned window spanning three words.
        mem[8]  = 32'hAAAA0000;
        mem[9]  = 32'hCCCCBBBB;
        mem[10] = 32'hEEEEDDDD;
        do_req(25'h11, 1, 0);
        check("misaligned_const", model_window(25'h11), 64'hDDDDCCCCBBBBAAAA);

        // Word-address wrap at the top of memory.
        mem[24'hFFFFFF] = 32'h7777_6666;
        mem[0]          = 32'h9999_8888;
        mem[1]          = 32'hBBBB_AAAA;
        do_req(25'h1FFFFFF, 1, 0);

        // Backpressure held for 5 cycles.
        do_req(25'h20, 2, 5);

        // Flush during WAIT with the read returning 3 cycles later.
        mem_lat = 3;
        start_req(25'h40);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        tag_valid   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("flush_wait_no_resp", 64'(bus.resp_valid_o), 64'd0);
            @(negedge clk);
        end
        check("flush_wait_reads", 64'(issued_q.size()), 64'd1);
        check("flush_wait_idle", 64'(bus.req_ready_o), 64'd1);
        do_req(25'h40, 1, 0);

        // Flush in ISSUE: the strobe still goes out and is drained.
        mem_lat = 2;
        start_req(25'h51);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        tag_valid   = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_issue_reads", 64'(issued_q.size()), 64'd1);
        check("flush_issue_no_resp", 64'(bus.resp_valid_o), 64'd0);
        do_req(25'h51, 1, 1);

        // Flush while a response is waiting.
        mem_lat = 1;
        start_req(25'h60);
        repeat (4) @(negedge clk);
        check("flush_resp_pre", 64'(bus.resp_valid_o), 64'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        tag_valid   = 1'b0;
        check("flush_resp_drop", 64'(bus.resp_valid_o), 64'd0);
        check("flush_resp_idle", 64'(bus.req_ready_o), 64'd1);

        // Flush together with a request in IDLE: not accepted.
        issued_q.delete();
        bus.req_valid_i = 1'b1;
        bus.req_pc_i    = 25'h70;
        bus.flush_i     = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
        check("flush_idle_ready", 64'(bus.req_ready_o), 64'd1);
        check("flush_idle_no_req", 64'(bus.mem_req_o), 64'd0);
        @(negedge clk);
        check("flush_idle_reads", 64'(issued_q.size()), 64'd0);

        // Sequential-fetch pair that exercises word reuse when enabled.
        do_req(25'h10, 1, 0);
        do_req(25'h13, 1, 0);

        // Randomized mix of addresses, latencies and backpressure.
        pc_r = 25'h100;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3))
                0:       pc_r = PC_W'($urandom());
                1:       pc_r = pc_r + PC_W'($urandom_range(4, 1));
                2:       pc_r = 25'h1FFFFFC + PC_W'($urandom_range(3));
                default: pc_r = PC_W'($urandom_range(63));
            endcase
            if ($urandom_range(3) == 0) mem[int'(pc_r[PC_W-1:1])] = $urandom();
            do_req(pc_r, $urandom_range(3, 1), $urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
